// File: rtl/clock_time_counter_pkg.sv
// rtl/clock_time_counter_pkg.sv - shared FSM encodings, BCD limits and digit helper for the time counter
package clock_time_counter_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_t;

  // Limits held as two-digit BCD so they compare directly against the field registers
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  localparam int DEFAULT_TICK_DIV  = 1000;
  localparam int DEFAULT_DB_CYCLES = 20;

  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - button synchroniser, stable-level filter and single rising-edge press pulse
module btn_conditioner
  import clock_time_counter_pkg::*;
#(
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;

  // Any disagreement with the accepted level must persist DB_CYCLES cycles in a row
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_press <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/clock_time_counter.sv
// rtl/clock_time_counter.sv - HH:MM:SS BCD time-of-day counter with prescaler and hour/minute set FSM
module clock_time_counter
  import clock_time_counter_pkg::*;
#(
  parameter int TICK_DIV  = DEFAULT_TICK_DIV,
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] op0,
  output logic [7:0] op1,
  output logic [7:0] op2,
  output logic [7:0] op3,
  output logic [7:0] op4,
  output logic [7:0] op5,
  output logic [1:0] set_mode,
  output logic       sec_tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_sec_tick;
  logic [7:0]    r_hh;
  logic [7:0]    r_mm;
  logic [7:0]    r_ss;
  logic          w_mode_p;
  logic          w_inc_p;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_mode (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .i_btn   (btn_mode),
    .o_press (w_mode_p)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_inc (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .i_btn   (btn_inc),
    .o_press (w_inc_p)
  );

  // A mode press always wins over inc and over a pending second advance
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_presc    <= '0;
      r_sec_tick <= 1'b0;
      r_hh       <= 8'h00;
      r_mm       <= 8'h00;
      r_ss       <= 8'h00;
    end else begin
      r_sec_tick <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_mode_p) begin
            r_state <= ST_SET_HOUR;
            r_ss    <= 8'h00;
            r_presc <= '0;
          end else begin
            if (r_sec_tick) begin
              r_ss <= bcd_next(r_ss, SEC_MAX);
              if (r_ss == SEC_MAX) begin
                r_mm <= bcd_next(r_mm, MIN_MAX);
                if (r_mm == MIN_MAX) r_hh <= bcd_next(r_hh, HOUR_MAX);
              end
            end
            if (r_presc == PRESC_LAST) begin
              r_presc    <= '0;
              r_sec_tick <= 1'b1;
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
        end
        ST_SET_HOUR: begin
          if (w_mode_p)     r_state <= ST_SET_MIN;
          else if (w_inc_p) r_hh    <= bcd_next(r_hh, HOUR_MAX);
        end
        ST_SET_MIN: begin
          if (w_mode_p) begin
            r_state <= ST_RUN;
            r_presc <= '0;
          end else if (w_inc_p) begin
            r_mm <= bcd_next(r_mm, MIN_MAX);
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_presc <= '0;
        end
      endcase
    end
  end

  assign op0      = {4'h0, r_hh[7:4]};
  assign op1      = {4'h0, r_hh[3:0]};
  assign op2      = {4'h0, r_mm[7:4]};
  assign op3      = {4'h0, r_mm[3:0]};
  assign op4      = {4'h0, r_ss[7:4]};
  assign op5      = {4'h0, r_ss[3:0]};
  assign set_mode = r_state;
  assign sec_tick = r_sec_tick;

endmodule

// File: tb/tb_clock_time_counter.sv
// tb/tb_clock_time_counter.sv - self-checking bench for clock_time_counter
module tb_clock_time_counter;

  localparam int TD = 4;
  localparam int DB = 3;

  logic       clk1 = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] op0, op1, op2, op3, op4, op5;
  logic [1:0] set_mode;
  logic       sec_tick;
  logic [47:0] w_ops;

  int checks = 0;
  int errors = 0;
  int n_since = 0;
  int bad_digits = 0;

  clock_time_counter #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .op0      (op0),
    .op1      (op1),
    .op2      (op2),
    .op3      (op3),
    .op4      (op4),
    .op5      (op5),
    .set_mode (set_mode),
    .sec_tick (sec_tick)
  );

  always #5 clk1 = ~clk1;

  assign w_ops = {op0, op1, op2, op3, op4, op5};

  typedef struct packed {
    logic [4:0]  h;
    logic [5:0]  m;
    logic [15:0] n;
    logic [47:0] ops;
    logic        tick;
  } vec_t;

  vec_t vt [10];

  always @(negedge clk1) begin
    if (rst_n) begin
      if ((op0[7:4] | op1[7:4] | op2[7:4] | op3[7:4] | op4[7:4] | op5[7:4]) != 4'h0) bad_digits++;
      if (op0[3:0] > 2 || (op0[3:0] == 2 && op1[3:0] > 3) || op1[3:0] > 9 ||
          op2[3:0] > 5 || op3[3:0] > 9 || op4[3:0] > 5 || op5[3:0] > 9) bad_digits++;
      if (set_mode == 2'b11) bad_digits++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick_n(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk1);
      n_since++;
    end
  endtask

  function automatic logic [47:0] hms(input int s);
    int hh, mm, ss;
    hh = s / 3600;
    mm = (s / 60) % 60;
    ss = s % 60;
    return {4'h0, 4'(hh / 10), 4'h0, 4'(hh % 10), 4'h0, 4'(mm / 10),
            4'h0, 4'(mm % 10), 4'h0, 4'(ss / 10), 4'h0, 4'(ss % 10)};
  endfunction

  // Seconds shown n cycles after the prescaler restarted: one per TD cycles, visible one edge after the tick
  task automatic chk_run(input string nm, input int base);
    int s;
    s = (base + ((n_since > 0) ? (n_since - 1) / TD : 0)) % 86400;
    check({nm, "_time"}, w_ops, hms(s));
    check({nm, "_tick"}, sec_tick, (n_since > 0 && n_since % TD == 0));
  endtask

  task automatic do_reset;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    @(negedge clk1);
    rst_n = 1'b0;
    @(negedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
    n_since = 0;
  endtask

  task automatic press(input logic m, input logic i, input int hold);
    btn_mode = m;
    btn_inc  = i;
    tick_n(hold);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick_n(7);
  endtask

  task automatic enter_run;
    logic ok;
    ok = 1'b0;
    btn_mode = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk1);
      if (set_mode == 2'b00) ok = 1'b1;
    end
    check("enter_run", ok, 1);
    n_since = 0;
    btn_mode = 1'b0;
  endtask

  task automatic set_hm(input int h, input int m);
    do_reset();
    press(1'b1, 1'b0, 7);
    for (int i = 0; i < h; i++) press(1'b0, 1'b1, 7);
    press(1'b1, 1'b0, 7);
    for (int i = 0; i < m; i++) press(1'b0, 1'b1, 7);
    enter_run();
  endtask

  initial begin
    int t;
    int h, m, n;

    vt[0] = '{5'd0,  6'd0,  16'd4,   48'h000000000000, 1'b1};
    vt[1] = '{5'd0,  6'd0,  16'd5,   48'h000000000001, 1'b0};
    vt[2] = '{5'd23, 6'd59, 16'd233, 48'h020305090508, 1'b0};
    vt[3] = '{5'd23, 6'd59, 16'd237, 48'h020305090509, 1'b0};
    vt[4] = '{5'd23, 6'd59, 16'd240, 48'h020305090509, 1'b1};
    vt[5] = '{5'd23, 6'd59, 16'd241, 48'h000000000000, 1'b0};
    vt[6] = '{5'd0,  6'd9,  16'd241, 48'h000001000000, 1'b0};
    vt[7] = '{5'd0,  6'd59, 16'd241, 48'h000100000000, 1'b0};
    vt[8] = '{5'd9,  6'd59, 16'd241, 48'h010000000000, 1'b0};
    vt[9] = '{5'd19, 6'd59, 16'd241, 48'h020000000000, 1'b0};

    // Reset state and first tick after release
    @(negedge clk1);
    @(negedge clk1);
    check("reset_ops", w_ops, 48'h0);
    check("reset_mode", set_mode, 2'b00);
    check("reset_tick", sec_tick, 1'b0);
    rst_n = 1'b1;
    n_since = 0;
    for (int k = 1; k <= 5; k++) begin
      tick_n(1);
      chk_run("reset_seq", 0);
    end

    for (int r = 0; r < 10; r++) begin
      set_hm(int'(vt[r].h), int'(vt[r].m));
      tick_n(int'(vt[r].n));
      check($sformatf("vec%0d_ops", r), w_ops, vt[r].ops);
      check($sformatf("vec%0d_tick", r), sec_tick, vt[r].tick);
    end

    // inc presses are ignored while running
    do_reset();
    press(1'b0, 1'b1, 7);
    press(1'b0, 1'b1, 7);
    chk_run("inc_in_run", 0);

    // Full set flow starting from 12:34:56
    set_hm(12, 34);
    tick_n(225);
    chk_run("pre_set", 12 * 3600 + 34 * 60);
    press(1'b1, 1'b0, 7);
    check("set_hour_mode", set_mode, 2'b01);
    check("set_hour_ss", w_ops, hms(12 * 3600 + 34 * 60));
    t = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk1);
      if (sec_tick) t++;
    end
    check("no_tick_50", t, 0);
    check("hold_50", w_ops, hms(12 * 3600 + 34 * 60));
    for (int k = 0; k < 13; k++) press(1'b0, 1'b1, 7);
    check("hour_13", w_ops, hms(1 * 3600 + 34 * 60));
    press(1'b1, 1'b0, 7);
    check("set_min_mode", set_mode, 2'b10);
    btn_inc = 1'b1;
    tick_n(2);
    btn_inc = 1'b0;
    tick_n(10);
    check("glitch", w_ops, hms(1 * 3600 + 34 * 60));
    press(1'b0, 1'b1, 40);
    check("held_40", w_ops, hms(1 * 3600 + 35 * 60));
    for (int k = 0; k < 29; k++) press(1'b0, 1'b1, 7);
    check("min_30", w_ops, hms(1 * 3600 + 4 * 60));
    enter_run();
    for (int k = 1; k <= 5; k++) begin
      tick_n(1);
      chk_run("after_set", 1 * 3600 + 4 * 60);
    end

    // Mode and inc together in SET_HOUR, then reset while in SET_MIN
    do_reset();
    press(1'b1, 1'b0, 7);
    press(1'b0, 1'b1, 7);
    press(1'b1, 1'b1, 7);
    check("both_mode", set_mode, 2'b10);
    check("both_hh", w_ops, hms(3600));
    press(1'b0, 1'b1, 7);
    press(1'b0, 1'b1, 7);
    check("min_2", w_ops, hms(3600 + 120));
    btn_inc = 1'b1;
    tick_n(3);
    rst_n = 1'b0;
    #1;
    check("midset_ops", w_ops, 48'h0);
    check("midset_mode", set_mode, 2'b00);
    btn_inc = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
    press(1'b1, 1'b0, 7);
    check("post_rst_mode", set_mode, 2'b01);
    check("post_rst_ops", w_ops, 48'h0);

    // Randomized preload and run length against the arithmetic model
    for (int r = 0; r < 5; r++) begin
      h = int'($urandom_range(0, 23));
      m = int'($urandom_range(0, 59));
      n = int'($urandom_range(1, 300));
      set_hm(h, m);
      tick_n(n);
      chk_run($sformatf("rand%0d", r), h * 3600 + m * 60);
    end

    check("digit_legal", bad_digits, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
